qgate_scheduler: RTL and testbench

QGATE_SCHEDULER -- requirements
Module: qgate_scheduler

---
 rtl/qgate_scheduler_pkg.sv | 23 ++
 rtl/amp_regfile.sv | 58 +++++
 rtl/qgate_scheduler.sv | 160 ++++++++++++++++
 tb/tb_qgate_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qgate_scheduler_pkg.sv
// Shared types and constants for the Hadamard gate scheduler.
// Holds the FSM encoding, FP32 constants and the pair-index helper.
package qgate_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        FINISH
    } state_e;

    localparam logic [31:0] ONE       = 32'h3f800000;
    localparam logic [31:0] INV_SQRT2 = 32'h3f3504f3;

    // Lower index of pair number cnt: cnt with a zero inserted at bit position t.
    function automatic logic [31:0] pair_index(input logic [31:0] cnt, input logic [4:0] t);
        logic [31:0] low_mask;
        low_mask = (32'd1 << t) - 32'd1;
        return ((cnt & ~low_mask) << 1) | (cnt & low_mask);
    endfunction

endpackage

// File: rtl/amp_regfile.sv
// Amplitude store: host read/write port plus a dual read/write port for the scheduler.
// Host read data is registered (1 cycle); scheduler reads are combinational.
module amp_regfile
    import qgate_scheduler_pkg::*;
#(
    parameter int NQ = 3,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_wr_en,
    input  logic [NQ-1:0] host_addr,
    input  logic [W-1:0]  host_wr_data,
    output logic [W-1:0]  host_rd_data,
    input  logic [NQ-1:0] sched_addr_a,
    input  logic [NQ-1:0] sched_addr_b,
    output logic [W-1:0]  sched_rd_a,
    output logic [W-1:0]  sched_rd_b,
    input  logic          sched_wr_en,
    input  logic [W-1:0]  sched_wr_a,
    input  logic [W-1:0]  sched_wr_b
);
    localparam int N = 2 ** NQ;

    logic [W-1:0] amp_q [N];
    logic [W-1:0] amp_d [N];
    logic [W-1:0] rd_q, rd_d;

    always_comb begin
        amp_d = amp_q;
        if (host_wr_en) begin
            amp_d[host_addr] = host_wr_data;
        end
        if (sched_wr_en) begin
            amp_d[sched_addr_a] = sched_wr_a;
            amp_d[sched_addr_b] = sched_wr_b;
        end
        rd_d = amp_q[host_addr];
    end

    // Reset loads the |0...0> basis state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                amp_q[k] <= (k == 0) ? W'(ONE) : '0;
            end
            rd_q <= '0;
        end else begin
            amp_q <= amp_d;
            rd_q  <= rd_d;
        end
    end

    assign host_rd_data = rd_q;
    assign sched_rd_a   = amp_q[sched_addr_a];
    assign sched_rd_b   = amp_q[sched_addr_b];

endmodule

// File: rtl/qgate_scheduler.sv
// Walks every amplitude pair of a Hadamard on target qubit t through an external unit.
// Per pair: ISSUE, WAIT (bounded by TMO), WRITE; cmd_ready only in IDLE.
module qgate_scheduler
    import qgate_scheduler_pkg::*;
#(
    parameter int NQ  = 3,
    parameter int W   = 32,
    parameter int TMO = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic [$clog2(NQ)-1:0] cmd_target,
    output logic                  cmd_ready,
    input  logic                  amp_wr_en,
    input  logic [NQ-1:0]         amp_addr,
    input  logic [W-1:0]          amp_wr_data,
    output logic [W-1:0]          amp_rd_data,
    output logic [W-1:0]          hadamard_up,
    output logic [W-1:0]          hadamard_down,
    output logic                  hadamard_go,
    input  logic [W-1:0]          hadamard_upout,
    input  logic [W-1:0]          hadamard_downout,
    input  logic                  hadamard_done,
    input  logic                  hadamard_running,
    output logic                  busy,
    output logic                  gate_done,
    output logic                  error
);
    localparam int TW = $clog2(NQ);
    localparam int PW = NQ - 1;
    localparam int CW = $clog2(TMO + 1);

    state_e        state_q, state_d;
    logic [TW-1:0] target_q, target_d;
    logic [PW-1:0] pair_q, pair_d;
    logic [CW-1:0] wait_q, wait_d, wait_inc;
    logic [W-1:0]  up_q, up_d, down_q, down_d;
    logic [W-1:0]  res_a_q, res_a_d, res_b_q, res_b_d;
    logic          go_q, go_d, error_q, error_d;
    logic          sched_wr_en, host_wr_en;
    logic [NQ-1:0] idx_a, idx_b;
    logic [W-1:0]  rd_a, rd_b;

    assign idx_a      = NQ'(pair_index(32'(pair_q), 5'(target_q)));
    assign idx_b      = idx_a | (NQ'(1) << target_q);
    assign wait_inc   = wait_q + CW'(1);
    assign host_wr_en = amp_wr_en && (state_q == IDLE);

    amp_regfile #(.NQ(NQ), .W(W)) u_amp (
        .clk          (clk),
        .reset        (reset),
        .host_wr_en   (host_wr_en),
        .host_addr    (amp_addr),
        .host_wr_data (amp_wr_data),
        .host_rd_data (amp_rd_data),
        .sched_addr_a (idx_a),
        .sched_addr_b (idx_b),
        .sched_rd_a   (rd_a),
        .sched_rd_b   (rd_b),
        .sched_wr_en  (sched_wr_en),
        .sched_wr_a   (res_a_q),
        .sched_wr_b   (res_b_q)
    );

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        pair_d      = pair_q;
        wait_d      = wait_q;
        up_d        = up_q;
        down_d      = down_q;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        go_d        = 1'b0;
        error_d     = error_q;
        sched_wr_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (int'(cmd_target) >= NQ) begin
                        error_d = 1'b1;
                    end else begin
                        target_d = cmd_target;
                        pair_d   = '0;
                        state_d  = ISSUE;
                    end
                end
            end
            // Operands register together with go and stay frozen until WRITE.
            ISSUE: begin
                up_d   = rd_a;
                down_d = rd_b;
                wait_d = '0;
                if (!hadamard_running) begin
                    go_d    = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (hadamard_done) begin
                    res_a_d = hadamard_upout;
                    res_b_d = hadamard_downout;
                    state_d = WRITE;
                end else if (wait_inc == CW'(TMO)) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_inc;
                end
            end
            WRITE: begin
                sched_wr_en = 1'b1;
                if (pair_q == '1) begin
                    state_d = FINISH;
                end else begin
                    pair_d  = pair_q + PW'(1);
                    state_d = ISSUE;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            pair_q   <= '0;
            wait_q   <= '0;
            up_q     <= '0;
            down_q   <= '0;
            res_a_q  <= '0;
            res_b_q  <= '0;
            go_q     <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            pair_q   <= pair_d;
            wait_q   <= wait_d;
            up_q     <= up_d;
            down_q   <= down_d;
            res_a_q  <= res_a_d;
            res_b_q  <= res_b_d;
            go_q     <= go_d;
            error_q  <= error_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign gate_done     = (state_q == FINISH);
    assign hadamard_go   = go_q;
    assign hadamard_up   = up_q;
    assign hadamard_down = down_q;
    assign error         = error_q;

endmodule

// File: tb/tb_qgate_scheduler.sv
// Directed bench for qgate_scheduler with a behavioural Hadamard unit and an operand scoreboard.
module tb_qgate_scheduler;
    import qgate_scheduler_pkg::*;

    localparam int NQ  = 3;
    localparam int W   = 32;
    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        reset, cmd_valid, cmd_ready, amp_wr_en;
    logic [1:0]  cmd_target;
    logic [2:0]  amp_addr;
    logic [31:0] amp_wr_data, amp_rd_data, hadamard_up, hadamard_down;
    logic [31:0] hadamard_upout = '0, hadamard_downout = '0;
    logic        hadamard_go, hadamard_running, busy, gate_done, error;
    logic        hadamard_done = 1'b0;

    int          n_cmp = 0, n_err = 0;
    int          go_cnt = 0, done_cnt = 0;
    logic [31:0] shadow [8];
    logic [63:0] exp_q [$];
    bit          model_en, mactive = 1'b0;
    int          mlat, mcnt;
    logic [31:0] ma, mb;

    qgate_scheduler #(.NQ(NQ), .W(W), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_target(cmd_target),
        .cmd_ready(cmd_ready), .amp_wr_en(amp_wr_en), .amp_addr(amp_addr),
        .amp_wr_data(amp_wr_data), .amp_rd_data(amp_rd_data),
        .hadamard_up(hadamard_up), .hadamard_down(hadamard_down), .hadamard_go(hadamard_go),
        .hadamard_upout(hadamard_upout), .hadamard_downout(hadamard_downout),
        .hadamard_done(hadamard_done), .hadamard_running(hadamard_running),
        .busy(busy), .gate_done(gate_done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = 11'(f[30:23]) + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [23:0] m;
        logic [7:0]  e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = 8'(d[62:52] - 11'd896);
        m = {1'b0, d[51:29]};
        if (d[28] && ((d[27:0] != 28'd0) || d[29])) m = m + 24'd1;
        if (m[23]) e = e + 8'd1;
        return {d[63], e, m[22:0]};
    endfunction

    function automatic logic [31:0] h_up(input logic [31:0] a, input logic [31:0] b);
        return r2f((f2r(a) + f2r(b)) * f2r(INV_SQRT2));
    endfunction

    function automatic logic [31:0] h_dn(input logic [31:0] a, input logic [31:0] b);
        return r2f((f2r(a) - f2r(b)) * f2r(INV_SQRT2));
    endfunction

    function automatic bit ulp_close(input logic [31:0] o, input logic [31:0] e);
        logic [31:0] diff;
        if (o[30:0] <= 31'd1 && e[30:0] <= 31'd1) return 1'b1;
        if (o[31] != e[31]) return 1'b0;
        diff = (o > e) ? o - e : e - o;
        return diff <= 32'd1;
    endfunction

    // Behavioural Hadamard unit plus go/operand scoreboard, all sampled on the falling edge.
    always @(negedge clk) begin
        hadamard_done = 1'b0;
        if (reset) begin
            mactive = 1'b0;
        end else begin
            if (mactive) begin
                check("op_stable", {hadamard_up, hadamard_down}, {ma, mb});
                if (mcnt == 0) begin
                    hadamard_done    = 1'b1;
                    hadamard_upout   = h_up(ma, mb);
                    hadamard_downout = h_dn(ma, mb);
                    mactive          = 1'b0;
                end else begin
                    mcnt--;
                end
            end
            if (hadamard_go) begin
                go_cnt++;
                check("go_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check("go_operands", {hadamard_up, hadamard_down}, exp_q.pop_front());
                end
                if (model_en) begin
                    ma = hadamard_up; mb = hadamard_down; mcnt = mlat; mactive = 1'b1;
                end
            end
            if (gate_done) done_cnt++;
        end
    end

    task automatic reset_shadow();
        for (int i = 0; i < 8; i++) shadow[i] = (i == 0) ? ONE : 32'd0;
        exp_q.delete();
    endtask

    task automatic apply_gate(input int t);
        logic [31:0] a, b;
        int j;
        for (int i = 0; i < 8; i++) begin
            if (((i >> t) & 1) == 0) begin
                j = i | (1 << t);
                a = shadow[i]; b = shadow[j];
                exp_q.push_back({a, b});
                shadow[i] = h_up(a, b);
                shadow[j] = h_dn(a, b);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; reset_shadow();
        @(negedge clk); @(negedge clk); reset = 1'b0;
    endtask

    task automatic host_write(input int a, input logic [31:0] d);
        @(negedge clk); amp_wr_en = 1'b1; amp_addr = 3'(a); amp_wr_data = d; shadow[a] = d;
        @(negedge clk); amp_wr_en = 1'b0;
    endtask

    task automatic send_cmd(input int t);
        @(negedge clk); cmd_valid = 1'b1; cmd_target = 2'(t);
        @(negedge clk); cmd_valid = 1'b0;
    endtask

    task automatic read_amp(input int a, output logic [31:0] d);
        @(negedge clk); amp_addr = 3'(a);
        @(negedge clk); d = amp_rd_data;
    endtask

    task automatic check_store(input string tag);
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            read_amp(i, d);
            check($sformatf("%s[%0d]", tag, i), 64'(d), 64'(shadow[i]));
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (gate_done) begin seen = 1'b1; break; end
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_go(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (hadamard_go) begin seen = 1'b1; break; end
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        logic [31:0] d;
        int g0, d0;
        bit stall_go;
        reset = 1'b1; cmd_valid = 1'b0; cmd_target = '0; amp_wr_en = 1'b0;
        amp_addr = '0; amp_wr_data = '0; hadamard_running = 1'b0;
        model_en = 1'b1; mlat = 2;
        reset_shadow();

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_gate_done", 64'(gate_done), 64'd0);
        check("rst_go", 64'(hadamard_go), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_operands", {hadamard_up, hadamard_down}, 64'd0);
        check("rst_rd_data", 64'(amp_rd_data), 64'd0);
        @(negedge clk); reset = 1'b0;
        check_store("rst_amp");

        // H on qubit 0 from |000>
        g0 = go_cnt;
        apply_gate(0); send_cmd(0); wait_done("h0_done", 200);
        check("h0_go_count", 64'(go_cnt - g0), 64'd4);
        check("h0_queue_empty", 64'(exp_q.size()), 64'd0);
        read_amp(0, d); check("h0_amp0", 64'(d), 64'h3f3504f3);
        read_amp(1, d); check("h0_amp1", 64'(d), 64'h3f3504f3);
        check_store("h0_amp");

        // Second H on qubit 0 returns to |000> within rounding
        apply_gate(0); send_cmd(0); wait_done("hh_done", 200);
        read_amp(0, d); check("hh_amp0_ulp", 64'(ulp_close(d, ONE)), 64'd1);
        read_amp(1, d); check("hh_amp1_ulp", 64'(ulp_close(d, 32'd0)), 64'd1);

        // H on qubit 2; last host write shares the command cycle; unit busy at start
        do_reset();
        host_write(0, 32'd0); host_write(1, 32'h40000000); host_write(6, 32'h40400000);
        shadow[4] = ONE;
        apply_gate(2);
        g0 = go_cnt;
        @(negedge clk);
        hadamard_running = 1'b1;
        amp_wr_en = 1'b1; amp_addr = 3'd4; amp_wr_data = ONE;
        cmd_valid = 1'b1; cmd_target = 2'd2;
        @(negedge clk); amp_wr_en = 1'b0; cmd_valid = 1'b0;
        stall_go = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); stall_go |= hadamard_go;
        end
        check("stall_no_go", 64'(stall_go), 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
        hadamard_running = 1'b0;
        wait_done("t2_done", 300);
        check("t2_go_count", 64'(go_cnt - g0), 64'd4);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        read_amp(0, d); check("t2_amp0", 64'(d), 64'h3f3504f3);
        read_amp(4, d); check("t2_amp4", 64'(d), 64'hbf3504f3);
        check_store("t2_amp");

        // Host write while busy is dropped
        mlat = 30;
        apply_gate(1); send_cmd(1);
        repeat (5) @(negedge clk);
        check("bw_busy", 64'(busy), 64'd1);
        amp_wr_en = 1'b1; amp_addr = 3'd3; amp_wr_data = 32'hdeadbeef;
        @(negedge clk); amp_wr_en = 1'b0;
        wait_done("bw_done", 400);
        mlat = 2;
        check_store("bw_amp");

        // Reset while waiting on the unit
        model_en = 1'b0;
        exp_q.push_back({shadow[0], shadow[1]});
        send_cmd(0); wait_go("rw_go");
        repeat (3) @(negedge clk);
        check("rw_busy", 64'(busy), 64'd1);
        g0 = go_cnt; d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("rw_idle", 64'(cmd_ready), 64'd1);
        check("rw_not_busy", 64'(busy), 64'd0);
        reset = 1'b0; reset_shadow();
        repeat (5) @(negedge clk);
        check("rw_no_go", 64'(go_cnt - g0), 64'd0);
        check("rw_no_done", 64'(done_cnt - d0), 64'd0);
        check_store("rw_amp");

        // Out-of-range target
        check("inv_pre_error", 64'(error), 64'd0);
        g0 = go_cnt;
        send_cmd(3);
        repeat (4) @(negedge clk);
        check("inv_error", 64'(error), 64'd1);
        check("inv_no_go", 64'(go_cnt - g0), 64'd0);
        check("inv_ready", 64'(cmd_ready), 64'd1);
        do_reset();
        check("inv_error_cleared", 64'(error), 64'd0);

        // Timeout: unit never answers
        exp_q.push_back({shadow[0], shadow[2]});
        d0 = done_cnt;
        send_cmd(1); wait_go("to_go");
        repeat (TMO - 5) @(negedge clk);
        check("to_error_early", 64'(error), 64'd0);
        check("to_busy_early", 64'(busy), 64'd1);
        repeat (10) @(negedge clk);
        check("to_error", 64'(error), 64'd1);
        check("to_idle", 64'(cmd_ready), 64'd1);
        check("to_no_done", 64'(done_cnt - d0), 64'd0);
        check_store("to_amp");
        check("to_error_sticky", 64'(error), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
